// File: rtl/project_pkg.sv
// Shared string-sender definitions: string IDs used by the mode controllers,
// ROM geometry. Optional CR/LF suffix is selected by STR_SENDER_CRLF_EN.
package project_pkg;

    localparam int STR_ID_W    = 3;
    localparam int STR_MAX_LEN = 16;

    typedef enum logic [STR_ID_W-1:0] {
        STR_MODE_INPUT = 3'd0,
        STR_MODE_GEN   = 3'd1,
        STR_MODE_SHOW  = 3'd2,
        STR_MODE_CALC  = 3'd3,
        STR_MODE_SET   = 3'd4,
        STR_ERROR      = 3'd5,
        STR_OK         = 3'd6,
        STR_EMPTY      = 3'd7
    } str_id_t;

endpackage

// File: rtl/str_sender_rom.sv
// String table for str_sender: combinational (id, index) -> character and
// id -> total length. STR_SENDER_CRLF_EN appends 0D 0A to every entry.
module str_rom
    import project_pkg::*;
#(
    parameter int MAX_LEN = STR_MAX_LEN,
    parameter int ID_W    = STR_ID_W,
    parameter int LEN_W   = $clog2(MAX_LEN + 2)
) (
    input  logic [ID_W-1:0]  id,
    input  logic [LEN_W-1:0] index,
    output logic [7:0]       ch,
    output logic [LEN_W-1:0] len
);

    logic [MAX_LEN*8-1:0] body;
    logic [LEN_W-1:0]     body_len;
    logic [LEN_W-1:0]     rev;

    // Literals are right-justified, so character i sits at byte (body_len-1-i).
    always_comb begin
        body     = '0;
        body_len = '0;
        case (id)
            ID_W'(STR_MODE_INPUT): begin body[8*10-1:0] = "mode-input"; body_len = LEN_W'(10); end
            ID_W'(STR_MODE_GEN):   begin body[8*8-1:0]  = "mode-gen";   body_len = LEN_W'(8);  end
            ID_W'(STR_MODE_SHOW):  begin body[8*9-1:0]  = "mode-show";  body_len = LEN_W'(9);  end
            ID_W'(STR_MODE_CALC):  begin body[8*9-1:0]  = "mode-calc";  body_len = LEN_W'(9);  end
            ID_W'(STR_MODE_SET):   begin body[8*8-1:0]  = "mode-set";   body_len = LEN_W'(8);  end
            ID_W'(STR_ERROR):      begin body[8*5-1:0]  = "error";      body_len = LEN_W'(5);  end
            ID_W'(STR_OK):         begin body[8*2-1:0]  = "ok";         body_len = LEN_W'(2);  end
            default:               begin body = '0;                     body_len = '0;         end
        endcase
    end

    always_comb begin
        rev = body_len - LEN_W'(1) - index;
        ch  = 8'h00;
        if (index < body_len) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (LEN_W'(i) == rev) ch = body[i*8 +: 8];
            end
        end
`ifdef STR_SENDER_CRLF_EN
        else if (index == body_len) begin
            ch = 8'h0D;
        end else if (index == body_len + LEN_W'(1)) begin
            ch = 8'h0A;
        end
`endif
    end

`ifdef STR_SENDER_CRLF_EN
    assign len = body_len + LEN_W'(2);
`else
    assign len = body_len;
`endif

endmodule

// File: rtl/str_sender.sv
// Sends a ROM string selected by ID to the UART transmitter over valid/ready,
// then pulses done. Build with STR_SENDER_CRLF_EN to append CR/LF.
module str_sender
    import project_pkg::*;
#(
    parameter int MAX_LEN = STR_MAX_LEN,
    parameter int ID_W    = STR_ID_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            str_start,
    input  logic [ID_W-1:0] str_id,
    input  logic            abort,
    output logic            ready,
    output logic            done,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready
);

    localparam int LEN_W = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t           state;
    logic [ID_W-1:0]  id_q;
    logic [LEN_W-1:0] index;
    logic [ID_W-1:0]  rom_id;
    logic [LEN_W-1:0] rom_idx;
    logic [LEN_W-1:0] rom_len;
    logic [7:0]       rom_ch;

    // In IDLE the ROM looks at the incoming ID so the first byte is ready at start.
    always_comb begin
        rom_id  = id_q;
        rom_idx = index + LEN_W'(1);
        if (state == IDLE) begin
            rom_id  = str_id;
            rom_idx = '0;
        end
    end

    str_rom #(
        .MAX_LEN(MAX_LEN),
        .ID_W   (ID_W),
        .LEN_W  (LEN_W)
    ) u_rom (
        .id   (rom_id),
        .index(rom_idx),
        .ch   (rom_ch),
        .len  (rom_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            id_q     <= '0;
            index    <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (str_start) begin
                        id_q  <= str_id;
                        index <= '0;
                        ready <= 1'b0;
                        if (rom_len != '0) begin
                            state    <= SEND;
                            tx_valid <= 1'b1;
                            tx_data  <= rom_ch;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        tx_valid <= 1'b0;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else if (tx_ready) begin
                        if (index == rom_len - LEN_W'(1)) begin
                            tx_valid <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            index   <= index + LEN_W'(1);
                            tx_data <= rom_ch;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= !abort;
                end
                default: begin
                    state    <= IDLE;
                    ready    <= 1'b1;
                    done     <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_str_sender.sv
// Directed bench for str_sender; expected bytes come from a local string table.
module tb_str_sender;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       str_start = 1'b0;
    logic [2:0] str_id = '0;
    logic       abort = 1'b0;
    logic       tx_ready = 1'b1;
    logic       ready, done, tx_valid;
    logic [7:0] tx_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int rdy_mode = 0;

    logic [7:0] got[$];
    int   done_cnt, done_cyc, first_v, last_v, vcnt, rdy_bad;
    bit   chk_stable = 1'b0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;

    string names[8] = '{"mode-input", "mode-gen", "mode-show", "mode-calc",
                        "mode-set", "error", "ok", ""};

    str_sender #(.MAX_LEN(16), .ID_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .str_start(str_start),
        .str_id   (str_id),
        .abort    (abort),
        .ready    (ready),
        .done     (done),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_len(input int id);
        int n = names[id].len();
`ifdef STR_SENDER_CRLF_EN
        n += 2;
`endif
        return n;
    endfunction

    function automatic logic [7:0] exp_byte(input int id, input int i);
        string s = names[id];
        if (i < s.len()) return s[i];
        return (i == s.len()) ? 8'h0D : 8'h0A;
    endfunction

    // Negedge monitor: handshakes, done pulses, hold-while-stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
        end else begin
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (tx_valid) begin
                vcnt++;
                last_v = cyc - t0;
                if (first_v < 0) first_v = cyc - t0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
                if (!ready) rdy_bad++;
            end
            if (chk_stable && pv && !pr) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, pd);
            end
            pv = tx_valid;
            pr = tx_ready;
            pd = tx_data;
        end
    end

    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (rdy_mode == 0) ? 1'b1 : (phase == 2);
            phase = (phase + 1) % 3;
        end
    end

    task automatic clear_mon();
        got.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_v  = -1;
        last_v   = -1;
        vcnt     = 0;
        rdy_bad  = 0;
    endtask

    task automatic start_str(input int id, input bit fresh);
        @(posedge clk);
        #1;
        str_start = 1'b1;
        str_id    = 3'(id);
        if (fresh) t0 = cyc;
        @(posedge clk);
        #1;
        str_start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic cmp_bytes(input string tag, input int id);
        int n = exp_len(id);
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            if (i < got.size()) check($sformatf("%s_b%0d", tag, i), got[i], exp_byte(id, i));
    endtask

    initial begin
        int n;
        clear_mon();
        repeat (2) @(posedge clk);
        #3;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // mode-set, tx_ready held high
        clear_mon();
        start_str(4, 1);
        wait_done(60);
        cmp_bytes("set", 4);
        check("set_first_valid", first_v, 1);
        check("set_valid_cycles", vcnt, exp_len(4));
        check("set_done_cnt", done_cnt, 1);
        check("set_done_cycle", done_cyc, last_v + 2);
        check("set_ready_at_done", rdy_bad, 0);

        // ok, tx_ready high one cycle in three
        clear_mon();
        rdy_mode = 1;
        chk_stable = 1'b1;
        start_str(6, 1);
        wait_done(80);
        chk_stable = 1'b0;
        rdy_mode = 0;
        cmp_bytes("ok_stall", 6);
        check("ok_stall_done_cnt", done_cnt, 1);
        check("ok_stall_ready_at_done", rdy_bad, 0);

        // empty entry
        clear_mon();
        start_str(7, 1);
        wait_done(20);
        cmp_bytes("empty", 7);
        check("empty_done_cnt", done_cnt, 1);
`ifndef STR_SENDER_CRLF_EN
        check("empty_no_valid", vcnt, 0);
        check("empty_done_cycle", done_cyc, 2);
`endif

        // start while busy is ignored
        clear_mon();
        start_str(1, 1);
        start_str(5, 0);
        wait_done(60);
        cmp_bytes("busy", 1);
        check("busy_done_cnt", done_cnt, 1);

        // abort while the 4th byte of mode-input is presented
        clear_mon();
        start_str(0, 1);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_valid_before", tx_valid, 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_valid_after", tx_valid, 0);
        check("abort_ready_after", ready, 1);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check($sformatf("abort_b%0d", i), got[i], exp_byte(0, i));

        clear_mon();
        start_str(6, 1);
        wait_done(60);
        cmp_bytes("after_abort", 6);
        check("after_abort_done_cnt", done_cnt, 1);

        // abort coinciding with the last byte's acceptance
        clear_mon();
        n = exp_len(6);
        start_str(6, 1);
        repeat (n - 1) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_last_no_done", done_cnt, 0);
        check("abort_last_count", got.size(), n);
        check("abort_last_ready", ready, 1);

        // asynchronous reset in the middle of a string
        clear_mon();
        start_str(2, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid, 0);
        check("arst_ready", ready, 1);
        check("arst_done", done, 0);
        @(posedge clk);
        #3;
        clear_mon();
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("arst_no_bytes", got.size(), 0);
        check("arst_no_done", done_cnt, 0);
        check("arst_idle_valid", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
